beep_scheduler: RTL and testbench

BEEP_SCHEDULER -- requirements
Module: beep_scheduler

---
 rtl/beep_scheduler.sv | 244 ++++++++++++++++++++++++
 tb/tb_beep_scheduler.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/beep_scheduler.sv
// beep_scheduler: parking-sensor style beeper. Latches a two-digit BCD
// distance, maps it to a band, and sequences ON/OFF tone bursts whose
// off-time shrinks as the object gets closer. A key-click request can
// borrow the speaker between bursts.
//
// Optional build macro: BEEP_STALE_TIMEOUT_EN
//   defined   -> band is forced to 0 after STALE_MS ms without dist_valid
//   undefined -> last band persists indefinitely (STALE_MS has no effect)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | silent, waiting for a click request or a non-zero band
// ON    | tone burst, ON_MS long (band 1 re-arms for a continuous tone)
// OFF   | silent gap, length set by the band sampled on entry
// CLICK | key-click tone, CLICK_MS long, followed by a full OFF gap
module beep_scheduler #(
    parameter int TICK_DIV  = 50000,
    parameter int TONE_HALF = 65536,
    parameter int ON_MS     = 60,
    parameter int CLICK_MS  = 20,
    parameter int STALE_MS  = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] digit1,
    input  logic [3:0] digit0,
    input  logic       dist_valid,
    input  logic       click_req,
    output logic       click_ack,
    output logic       sound,
    output logic       led,
    output logic [2:0] band,
    output logic       busy
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
    localparam int SW = (STALE_MS > 0) ? $clog2(STALE_MS + 1) : 1;
    localparam int MW = 16;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ON    = 2'd1;
    localparam logic [1:0] S_OFF   = 2'd2;
    localparam logic [1:0] S_CLICK = 2'd3;

`ifdef BEEP_STALE_TIMEOUT_EN
    localparam bit STALE_EN = 1'b1;
`else
    // The stale counter still exists but never affects the band, so it
    // folds away in synthesis.
    localparam bit STALE_EN = 1'b0;
`endif

    logic [PW-1:0] presc_q, presc_d;
    logic          tick;
    logic [6:0]    num_q, num_d;
    logic [SW-1:0] stale_q, stale_d;
    logic          stale_hit;
    logic [2:0]    band_q, band_d;
    logic [1:0]    state_q, state_d;
    logic [MW-1:0] timer_q, timer_d;
    logic          phase_done;
    logic          grant;
    logic [TW-1:0] tone_q, tone_d;
    logic          sound_q, sound_d;
    logic          ack_q, ack_d;
    logic          tone_state;
    logic          tone_entry;

    function automatic logic [2:0] band_of(input logic [6:0] n);
        logic [2:0] b;
        if (n > 7'd36)       b = 3'd0;
        else if (n >= 7'd26) b = 3'd7;
        else if (n >= 7'd21) b = 3'd6;
        else if (n >= 7'd16) b = 3'd5;
        else if (n >= 7'd12) b = 3'd4;
        else if (n >= 7'd9)  b = 3'd3;
        else if (n >= 7'd7)  b = 3'd2;
        else                 b = 3'd1;
        return b;
    endfunction

    // Band 1 has no gap: an OFF entered from CLICK ends immediately.
    function automatic logic [MW-1:0] off_ms(input logic [2:0] b);
        logic [MW-1:0] t;
        case (b)
            3'd2:    t = MW'(50);
            3'd3:    t = MW'(100);
            3'd4:    t = MW'(150);
            3'd5:    t = MW'(200);
            3'd6:    t = MW'(300);
            3'd7:    t = MW'(400);
            default: t = '0;
        endcase
        return t;
    endfunction

    assign tick = (presc_q == PW'(TICK_DIV - 1));

    // Free-running millisecond prescaler
    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
    end

    // Distance latch; an invalid digit latches an out-of-range number
    always_comb begin
        num_d = num_q;
        if (dist_valid) begin
            if (digit1 > 4'd9 || digit0 > 4'd9) num_d = 7'd127;
            else                                num_d = 7'(digit1) * 7'd10 + 7'(digit0);
        end
    end

    // Milliseconds since the last measurement, saturating at the limit
    always_comb begin
        stale_d = stale_q;
        if (dist_valid)              stale_d = '0;
        else if (tick && !stale_hit) stale_d = stale_q + 1'b1;
    end

    assign stale_hit = STALE_EN && (stale_q == SW'(STALE_MS));

    // Band is registered one cycle behind the latched number
    always_comb begin
        band_d = stale_hit ? 3'd0 : band_of(num_q);
    end

    // A phase ends on the tick that exhausts the timer; a zero load ends at once
    assign phase_done = (timer_q == '0) || (tick && timer_q == MW'(1));

    // Sequencer: phase transitions and phase-timer (down-counter) loads
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        grant   = 1'b0;
        if (tick && timer_q != '0) timer_d = timer_q - 1'b1;
        case (state_q)
            S_IDLE: begin
                if (click_req) begin
                    state_d = S_CLICK;
                    timer_d = MW'(CLICK_MS);
                    grant   = 1'b1;
                end else if (band_q != 3'd0) begin
                    state_d = S_ON;
                    timer_d = MW'(ON_MS);
                end
            end
            S_ON: begin
                if (phase_done) begin
                    if (band_q == 3'd0) begin
                        state_d = S_IDLE;
                    end else if (band_q == 3'd1 && !click_req) begin
                        timer_d = MW'(ON_MS);
                    end else begin
                        // Band 1 with a pending click passes through a
                        // zero-length OFF so the click can be granted.
                        state_d = S_OFF;
                        timer_d = off_ms(band_q);
                    end
                end
            end
            S_OFF: begin
                if (band_q == 3'd0) begin
                    state_d = S_IDLE;
                end else if (click_req) begin
                    state_d = S_CLICK;
                    timer_d = MW'(CLICK_MS);
                    grant   = 1'b1;
                end else if (phase_done) begin
                    state_d = S_ON;
                    timer_d = MW'(ON_MS);
                end
            end
            S_CLICK: begin
                if (phase_done) begin
                    if (band_q != 3'd0) begin
                        state_d = S_OFF;
                        timer_d = off_ms(band_q);
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ON re-arm is not an entry, so a continuous tone keeps its phase
    assign tone_state = (state_d == S_ON) || (state_d == S_CLICK);
    assign tone_entry = tone_state && (state_d != state_q);

    // Square-wave generator, cleared on phase entry and whenever muted
    always_comb begin
        tone_d  = tone_q;
        sound_d = sound_q;
        if (!tone_state || !en || tone_entry) begin
            tone_d  = '0;
            sound_d = 1'b0;
        end else if (tone_q == TW'(TONE_HALF - 1)) begin
            tone_d  = '0;
            sound_d = !sound_q;
        end else begin
            tone_d = tone_q + 1'b1;
        end
    end

    // Grant pulse coincides with the first CLICK cycle
    always_comb begin
        ack_d = grant;
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            num_q   <= 7'd99;
            stale_q <= '0;
            band_q  <= 3'd0;
            state_q <= S_IDLE;
            timer_q <= '0;
            tone_q  <= '0;
            sound_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            num_q   <= num_d;
            stale_q <= stale_d;
            band_q  <= band_d;
            state_q <= state_d;
            timer_q <= timer_d;
            tone_q  <= tone_d;
            sound_q <= sound_d;
            ack_q   <= ack_d;
        end
    end

    assign click_ack = ack_q;
    assign sound     = sound_q;
    assign led       = (state_q == S_ON) || (state_q == S_CLICK);
    assign band      = band_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_beep_scheduler.sv
// Testbench for beep_scheduler: scenario tasks with a behavioural model of
// band mapping and phase-duration windows (N-1 .. N+1 ms).
module tb_beep_scheduler;

    localparam int TD  = 10;
    localparam int TH  = 4;
    localparam int ONM = 3;
    localparam int CLM = 2;
    localparam int STM = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] digit1;
    logic [3:0] digit0;
    logic       dist_valid;
    logic       click_req;
    logic       click_ack;
    logic       sound;
    logic       led;
    logic [2:0] band;
    logic       busy;

    int checks   = 0;
    int errors   = 0;
    int cur_band = 0;

    beep_scheduler #(
        .TICK_DIV (TD),
        .TONE_HALF(TH),
        .ON_MS    (ONM),
        .CLICK_MS (CLM),
        .STALE_MS (STM)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .digit1    (digit1),
        .digit0    (digit0),
        .dist_valid(dist_valid),
        .click_req (click_req),
        .click_ack (click_ack),
        .sound     (sound),
        .led       (led),
        .band      (band),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic int ref_band(input int d1, input int d0);
        int n;
        if (d1 > 9 || d0 > 9) return 0;
        n = d1 * 10 + d0;
        if (n > 36) return 0;
        if (n >= 26) return 7;
        if (n >= 21) return 6;
        if (n >= 16) return 5;
        if (n >= 12) return 4;
        if (n >= 9) return 3;
        if (n >= 7) return 2;
        return 1;
    endfunction

    function automatic int ref_off(input int b);
        int t;
        case (b)
            2: t = 50;
            3: t = 100;
            4: t = 150;
            5: t = 200;
            6: t = 300;
            7: t = 400;
            default: t = 0;
        endcase
        return t;
    endfunction

    function automatic int win_lo(input int ms);
        return (ms - 1) * TD;
    endfunction

    function automatic int win_hi(input int ms);
        return (ms + 1) * TD;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; dist_valid = 1'b0; click_req = 1'b0; en = 1'b1;
        digit1 = 4'd0; digit0 = 4'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cur_band = 0;
    endtask

    // Called at a negedge; returns band seen one cycle after the strobe and
    // leaves the bench at the negedge where the new band must be visible.
    task automatic send(input int d1, input int d0, output logic [2:0] mid);
        digit1 = 4'(d1); digit0 = 4'(d0); dist_valid = 1'b1;
        @(negedge clk);
        dist_valid = 1'b0;
        mid = band;
        @(negedge clk);
    endtask

    task automatic wait_led(input logic v, input int budget, output bit ok);
        int n;
        n = 0; ok = 1'b1;
        while (led !== v) begin
            @(negedge clk);
            n++;
            if (n > budget) begin ok = 1'b0; break; end
        end
    endtask

    task automatic run_phase(input logic v, input int budget, output int len,
                             output int snd_hi, output int busy_lo);
        len = 0; snd_hi = 0; busy_lo = 0;
        while (led === v && len <= budget) begin
            if (sound) snd_hi++;
            if (!busy) busy_lo++;
            len++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; dist_valid = 1'b0; click_req = 1'b1;
        digit1 = 4'd0; digit0 = 4'd5;
        repeat (3) @(negedge clk);
        checks++; if (led !== 1'b0) begin errors++; $display("FAIL reset_led got %b want 0", led); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (sound !== 1'b0) begin errors++; $display("FAIL reset_sound got %b want 0", sound); end
        checks++; if (band !== 3'd0) begin errors++; $display("FAIL reset_band got %0d want 0", band); end
        checks++; if (click_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", click_ack); end
        click_req = 1'b0;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (band !== 3'd0) begin errors++; $display("FAIL post_reset_band got %0d want 0", band); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b want 0", busy); end
    endtask

    task automatic test_band_map();
        int nums[$];
        int d1, d0, exp_b;
        logic [2:0] mid;
        nums = '{0, 6, 7, 8, 9, 11, 12, 15, 16, 20, 21, 25, 26, 36, 37, 99};
        do_reset();
        foreach (nums[i]) begin
            d1 = nums[i] / 10; d0 = nums[i] % 10;
            exp_b = ref_band(d1, d0);
            send(d1, d0, mid);
            checks++; if (mid !== 3'(cur_band)) begin errors++; $display("FAIL band_latency n=%0d got %0d want %0d", nums[i], mid, cur_band); end
            checks++; if (band !== 3'(exp_b)) begin errors++; $display("FAIL band_map n=%0d got %0d want %0d", nums[i], band, exp_b); end
            cur_band = exp_b;
        end
        for (int i = 0; i < 24; i++) begin
            d1 = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
            d0 = ($urandom_range(0, 5) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
            exp_b = ref_band(d1, d0);
            send(d1, d0, mid);
            checks++; if (band !== 3'(exp_b)) begin errors++; $display("FAIL band_rand d=%0d,%0d got %0d want %0d", d1, d0, band, exp_b); end
            cur_band = exp_b;
        end
    endtask

    task automatic test_continuous();
        logic [2:0] mid;
        logic prev;
        bit ok;
        int last_t, bad, ntr, led_lo;
        do_reset();
        send(0, 5, mid);
        checks++; if (band !== 3'd1) begin errors++; $display("FAIL cont_band got %0d want 1", band); end
        wait_led(1'b1, 5, ok);
        checks++; if (!ok) begin errors++; $display("FAIL cont_start led got %b want 1", led); end
        last_t = -1; bad = 0; ntr = 0; led_lo = 0; prev = sound;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (led !== 1'b1) led_lo++;
            if (sound !== prev) begin
                if (last_t >= 0 && (i - last_t) != TH) bad++;
                last_t = i; ntr++; prev = sound;
            end
        end
        checks++; if (led_lo != 0) begin errors++; $display("FAIL cont_led_low got %0d want 0", led_lo); end
        checks++; if (bad != 0) begin errors++; $display("FAIL cont_tone_period bad_intervals got %0d want 0", bad); end
        checks++; if (ntr < 35) begin errors++; $display("FAIL cont_toggles got %0d want >=35", ntr); end
    endtask

    task automatic test_cadence();
        logic [2:0] mid;
        bit ok;
        int hi, lo, s, b;
        do_reset();
        send(1, 0, mid);
        checks++; if (band !== 3'd3) begin errors++; $display("FAIL cad_band got %0d want 3", band); end
        wait_led(1'b1, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL cad_start led got %b want 1", led); end
        for (int p = 0; p < 2; p++) begin
            run_phase(1'b1, 60, hi, s, b);
            checks++; if (hi < win_lo(ONM) || hi > win_hi(ONM)) begin errors++; $display("FAIL cad_on_len got %0d want %0d..%0d", hi, win_lo(ONM), win_hi(ONM)); end
            run_phase(1'b0, 1100, lo, s, b);
            checks++; if (lo < win_lo(ref_off(3)) || lo > win_hi(ref_off(3))) begin errors++; $display("FAIL cad_off_len got %0d want %0d..%0d", lo, win_lo(ref_off(3)), win_hi(ref_off(3))); end
            checks++; if (s != 0) begin errors++; $display("FAIL cad_off_sound high_cycles got %0d want 0", s); end
            checks++; if (b != 0) begin errors++; $display("FAIL cad_off_busy low_cycles got %0d want 0", b); end
        end
    endtask

    task automatic test_stop_in_off();
        logic [2:0] mid;
        bit ok;
        do_reset();
        send(1, 0, mid);
        wait_led(1'b1, 20, ok);
        wait_led(1'b0, 60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stop_on_end led got %b want 0", led); end
        repeat (50) @(negedge clk);
        send(4, 0, mid);
        checks++; if (mid !== 3'd3) begin errors++; $display("FAIL stop_mid_band got %0d want 3", mid); end
        checks++; if (band !== 3'd0) begin errors++; $display("FAIL stop_band got %0d want 0", band); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy got %b want 0", busy); end
        send(1, 5, mid);
        checks++; if (band !== 3'd4) begin errors++; $display("FAIL stop_band15 got %0d want 4", band); end
        send(1, 10, mid);
        checks++; if (band !== 3'd0) begin errors++; $display("FAIL stop_band1A got %0d want 0", band); end
    endtask

    task automatic test_click_during_on();
        logic [2:0] mid;
        bit ok;
        int hi, early, n, cl, lo, s, b;
        do_reset();
        send(1, 0, mid);
        wait_led(1'b1, 20, ok);
        click_req = 1'b1;
        hi = 0; early = 0;
        while (led === 1'b1 && hi <= 60) begin
            if (click_ack) early++;
            hi++;
            @(negedge clk);
        end
        checks++; if (early != 0) begin errors++; $display("FAIL click_early acks got %0d want 0", early); end
        checks++; if (hi < win_lo(ONM) || hi > win_hi(ONM)) begin errors++; $display("FAIL click_on_len got %0d want %0d..%0d", hi, win_lo(ONM), win_hi(ONM)); end
        n = 0;
        while (click_ack !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        checks++; if (click_ack !== 1'b1) begin errors++; $display("FAIL click_grant ack got %b want 1", click_ack); end
        checks++; if (led !== 1'b1) begin errors++; $display("FAIL click_led got %b want 1", led); end
        click_req = 1'b0;
        @(negedge clk);
        checks++; if (click_ack !== 1'b0) begin errors++; $display("FAIL click_pulse ack got %b want 0", click_ack); end
        run_phase(1'b1, 60, cl, s, b);
        cl = cl + 1;
        checks++; if (cl < win_lo(CLM) || cl > win_hi(CLM)) begin errors++; $display("FAIL click_len got %0d want %0d..%0d", cl, win_lo(CLM), win_hi(CLM)); end
        run_phase(1'b0, 1100, lo, s, b);
        checks++; if (lo < win_lo(ref_off(3)) || lo > win_hi(ref_off(3))) begin errors++; $display("FAIL click_off_len got %0d want %0d..%0d", lo, win_lo(ref_off(3)), win_hi(ref_off(3))); end
    endtask

    task automatic test_en_off();
        logic [2:0] mid;
        bit ok;
        int hi, lo, s, b, total_s;
        do_reset();
        en = 1'b0;
        send(0, 8, mid);
        checks++; if (band !== 3'd2) begin errors++; $display("FAIL mute_band got %0d want 2", band); end
        wait_led(1'b1, 20, ok);
        total_s = 0;
        for (int p = 0; p < 2; p++) begin
            run_phase(1'b1, 60, hi, s, b);
            total_s += s;
            checks++; if (hi < win_lo(ONM) || hi > win_hi(ONM)) begin errors++; $display("FAIL mute_on_len got %0d want %0d..%0d", hi, win_lo(ONM), win_hi(ONM)); end
            run_phase(1'b0, 600, lo, s, b);
            total_s += s;
            checks++; if (lo < win_lo(ref_off(2)) || lo > win_hi(ref_off(2))) begin errors++; $display("FAIL mute_off_len got %0d want %0d..%0d", lo, win_lo(ref_off(2)), win_hi(ref_off(2))); end
        end
        checks++; if (total_s != 0) begin errors++; $display("FAIL mute_sound high_cycles got %0d want 0", total_s); end
        en = 1'b1;
    endtask

    task automatic test_click_idle();
        do_reset();
        digit1 = 4'd1; digit0 = 4'd7; dist_valid = 1'b1; click_req = 1'b1;
        @(negedge clk);
        dist_valid = 1'b0;
        checks++; if (click_ack !== 1'b1) begin errors++; $display("FAIL idle_click_ack got %b want 1", click_ack); end
        click_req = 1'b0;
        @(negedge clk);
        checks++; if (click_ack !== 1'b0) begin errors++; $display("FAIL idle_click_pulse got %b want 0", click_ack); end
        checks++; if (band !== 3'(ref_band(1, 7))) begin errors++; $display("FAIL idle_click_band got %0d want %0d", band, ref_band(1, 7)); end
        checks++; if (led !== 1'b1) begin errors++; $display("FAIL idle_click_led got %b want 1", led); end
    endtask

    task automatic test_reset_mid_tone();
        logic [2:0] mid;
        bit ok;
        int n, acks, busy_n;
        do_reset();
        send(0, 3, mid);
        wait_led(1'b1, 20, ok);
        click_req = 1'b1;
        n = 0;
        while (sound !== 1'b1 && n < 12) begin @(negedge clk); n++; end
        checks++; if (sound !== 1'b1) begin errors++; $display("FAIL midtone_sound_up got %b want 1", sound); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (sound !== 1'b0) begin errors++; $display("FAIL midtone_reset_sound got %b want 0", sound); end
        checks++; if (led !== 1'b0) begin errors++; $display("FAIL midtone_reset_led got %b want 0", led); end
        checks++; if (band !== 3'd0) begin errors++; $display("FAIL midtone_reset_band got %0d want 0", band); end
        @(negedge clk);
        click_req = 1'b0;
        rst_n = 1'b1;
        acks = 0; busy_n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (click_ack) acks++;
            if (busy) busy_n++;
        end
        checks++; if (acks != 0) begin errors++; $display("FAIL midtone_stale_click acks got %0d want 0", acks); end
        checks++; if (busy_n != 0) begin errors++; $display("FAIL midtone_busy cycles got %0d want 0", busy_n); end
        cur_band = 0;
    endtask

    task automatic test_stale();
        logic [2:0] mid;
        bit ok;
        do_reset();
        send(1, 3, mid);
        checks++; if (band !== 3'd4) begin errors++; $display("FAIL stale_band_init got %0d want 4", band); end
        repeat (300) @(negedge clk);
`ifdef BEEP_STALE_TIMEOUT_EN
        checks++; if (band !== 3'd0) begin errors++; $display("FAIL stale_band got %0d want 0", band); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stale_busy got %b want 0", busy); end
`else
        checks++; if (band !== 3'd4) begin errors++; $display("FAIL stale_band got %0d want 4", band); end
        wait_led(1'b0, 60, ok);
        wait_led(1'b1, 1700, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stale_cadence led got %b want 1", led); end
`endif
    endtask

    task automatic test_random();
        logic [2:0] mid;
        int d1, d0, exp_b, n, inv_bad, band_bad, spurious;
        do_reset();
        inv_bad = 0; band_bad = 0; spurious = 0;
        for (int it = 0; it < 60; it++) begin
            en = ($urandom_range(0, 3) != 0);
            d1 = $urandom_range(0, 4);
            d0 = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
            exp_b = ref_band(d1, d0);
            send(d1, d0, mid);
            checks++; if (mid !== 3'(cur_band)) begin errors++; $display("FAIL rnd_latency it=%0d got %0d want %0d", it, mid, cur_band); end
            checks++; if (band !== 3'(exp_b)) begin errors++; $display("FAIL rnd_band it=%0d got %0d want %0d", it, band, exp_b); end
            cur_band = exp_b;
            if ($urandom_range(0, 3) == 0) click_req = 1'b1;
            n = $urandom_range(5, 60);
            @(negedge clk);
            for (int c = 0; c < n; c++) begin
                if (sound && !led) inv_bad++;
                if (sound && !en) inv_bad++;
                if (led && !busy) inv_bad++;
                if (band == 3'd0 && busy && !led) inv_bad++;
                if (band !== 3'(cur_band)) band_bad++;
                if (click_ack) begin
                    if (!click_req) spurious++;
                    click_req = 1'b0;
                end
                @(negedge clk);
            end
        end
        click_req = 1'b0;
        checks++; if (inv_bad != 0) begin errors++; $display("FAIL rnd_invariants violations got %0d want 0", inv_bad); end
        checks++; if (band_bad != 0) begin errors++; $display("FAIL rnd_band_hold cycles got %0d want 0", band_bad); end
        checks++; if (spurious != 0) begin errors++; $display("FAIL rnd_spurious_ack got %0d want 0", spurious); end
    endtask

    initial begin
        test_reset();
        test_band_map();
        test_continuous();
`ifndef BEEP_STALE_TIMEOUT_EN
        test_cadence();
        test_click_during_on();
        test_en_off();
`endif
        test_stop_in_off();
        test_click_idle();
        test_reset_mid_tone();
        test_stale();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
